// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial multiplier datapath: operand geometry,
// loader state encodings and a coefficient-slice helper.
package poly_pkg;

  localparam int COEF_W = 4;
  localparam int N_COEF = 4;
  localparam int OP_W   = COEF_W * N_COEF;

  typedef enum logic [1:0] {
    S_LOAD_A = 2'b00,
    S_LOAD_B = 2'b01,
    S_ISSUE  = 2'b10,
    S_BUSY   = 2'b11
  } load_state_e;

  // Coefficient idx of a packed polynomial; idx 0 is the constant term.
  function automatic logic [COEF_W-1:0] coef_slice(input logic [OP_W-1:0] poly,
                                                   input int unsigned idx);
    return poly[idx*COEF_W +: COEF_W];
  endfunction

endpackage

// File: rtl/poly_operand_loader_if.sv
// Operand hand-off between the loader (master) and the multiplier (slave).
interface poly_operand_loader_if;

  logic [poly_pkg::OP_W-1:0] a_coeffs;
  logic [poly_pkg::OP_W-1:0] b_coeffs;
  logic                      op_valid;
  logic                      op_ready;
  logic                      mult_done;

  // A transfer happens on a rising edge where op_valid && op_ready. Once
  // raised, op_valid and both operands hold until that edge; op_ready may be
  // high before op_valid. mult_done is a one-cycle completion pulse.
  modport master (
    output a_coeffs,
    output b_coeffs,
    output op_valid,
    input  op_ready,
    input  mult_done
  );

  modport slave (
    input  a_coeffs,
    input  b_coeffs,
    input  op_valid,
    output op_ready,
    output mult_done
  );

endinterface

// File: rtl/poly_operand_loader_btn_debounce.sv
// Push-button front end: synchroniser, stability counter and a registered
// one-cycle pulse on each accepted 0->1 level change.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic man_clk,
  input  logic man_reset_n,
  input  logic btn_in,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   synced;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_in};
    synced  = sync_q[SYNC_STAGES-1];
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    // Any cycle agreeing with the accepted level restarts the stability count.
    if (synced != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
        press_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge man_clk or negedge man_reset_n) begin
    if (!man_reset_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/poly_operand_loader.sv
// Captures operand A then B from the switch bank on debounced button presses,
// offers them to the multiplier and waits for its completion pulse.
module poly_operand_loader
  import poly_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  man_clk,
  input  logic                  man_reset_n,
  input  logic [OP_W-1:0]       bits,
  input  logic                  step_btn,
  poly_operand_loader_if.master op,
  output logic [1:0]            load_state
);

  logic press;

  btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .man_clk     (man_clk),
    .man_reset_n (man_reset_n),
    .btn_in      (step_btn),
    .press       (press)
  );

  load_state_e     state_q, state_d;
  logic [OP_W-1:0] a_q, a_d;
  logic [OP_W-1:0] b_q, b_d;
  logic            valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    // Presses outside the load states and mult_done outside S_BUSY fall through.
    case (state_q)
      S_LOAD_A: begin
        if (press) begin
          a_d     = bits;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (press) begin
          b_d     = bits;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (valid_q && op.op_ready) begin
          valid_d = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (op.mult_done) begin
          state_d = S_LOAD_A;
        end
      end
      default: state_d = S_LOAD_A;
    endcase
  end

  always_ff @(posedge man_clk or negedge man_reset_n) begin
    if (!man_reset_n) begin
      state_q <= S_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  assign op.a_coeffs = a_q;
  assign op.b_coeffs = b_q;
  assign op.op_valid = valid_q;
  assign load_state  = state_q;

endmodule

// File: tb/tb_poly_operand_loader.sv
// Directed bench for poly_operand_loader: capture sequence, debouncing,
// handshake, ignored events and asynchronous reset.
module tb_poly_operand_loader;
  import poly_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 16;

  logic        man_clk = 1'b0;
  logic        man_reset_n;
  logic [15:0] bits;
  logic        step_btn;
  logic [1:0]  load_state;
  int          lat;

  poly_operand_loader_if op_if ();

  poly_operand_loader #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .man_clk     (man_clk),
    .man_reset_n (man_reset_n),
    .bits        (bits),
    .step_btn    (step_btn),
    .op          (op_if.master),
    .load_state  (load_state)
  );

  // clock / reset
  always #5 man_clk = ~man_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge man_clk) begin
    if (man_reset_n && op_if.op_valid && op_if.op_ready) begin
      check_eq("xfer_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check_eq("xfer_operands", {op_if.a_coeffs, op_if.b_coeffs}, exp_q.pop_front());
    end
  end

  // driver tasks: inputs change 2 ns after the rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge man_clk);
    #2;
  endtask

  task automatic press_clean();
    step_btn = 1'b1;
    tick(30);
    step_btn = 1'b0;
    tick(30);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] target,
                            input int budget, output int cycles);
    cycles = 0;
    while (load_state !== target && cycles < budget) begin
      tick(1);
      cycles++;
    end
    if (load_state !== target) check_eq(tag, 32'(load_state), 32'(target));
  endtask

  initial begin
    man_reset_n     = 1'b0;
    bits            = 16'h0000;
    step_btn        = 1'b0;
    op_if.op_ready  = 1'b0;
    op_if.mult_done = 1'b0;
    tick(3);
    check_eq("rst_a", op_if.a_coeffs, 32'h0);
    check_eq("rst_b", op_if.b_coeffs, 32'h0);
    check_eq("rst_valid", op_if.op_valid, 32'h0);
    check_eq("rst_state", load_state, 32'(S_LOAD_A));
    man_reset_n = 1'b1;
    tick(2);

    // A then B capture; press-to-capture latency 18 +/- 1 cycles
    bits = 16'h0101;
    tick(2);
    step_btn = 1'b1;
    wait_state("t1_a_timeout", S_LOAD_B, 40, lat);
    check_eq("t1_latency_in_range", 32'(lat >= 17 && lat <= 19), 32'd1);
    check_eq("t1_a", op_if.a_coeffs, 32'h0101);
    check_eq("t1_valid_low_in_load_b", op_if.op_valid, 32'h0);
    step_btn = 1'b0;
    tick(30);
    bits = 16'h4321;
    tick(2);
    exp_q.push_back({16'h0101, 16'h4321});
    step_btn = 1'b1;
    wait_state("t1_b_timeout", S_ISSUE, 40, lat);
    check_eq("t1_b", op_if.b_coeffs, 32'h4321);
    tick(1);
    check_eq("t1_valid", op_if.op_valid, 32'h1);
    check_eq("t1_state_issue", load_state, 32'(S_ISSUE));
    step_btn = 1'b0;

    // op_valid holds while op_ready stays low
    tick(20);
    check_eq("t3_valid_held", op_if.op_valid, 32'h1);
    check_eq("t3_a_stable", op_if.a_coeffs, 32'h0101);
    check_eq("t3_b_coef3", 32'(coef_slice(op_if.b_coeffs, 3)), 32'h4);
    check_eq("t3_state_issue", load_state, 32'(S_ISSUE));
    op_if.op_ready = 1'b1;
    tick(1);
    check_eq("t3_valid_dropped", op_if.op_valid, 32'h0);
    check_eq("t3_state_busy", load_state, 32'(S_BUSY));
    op_if.op_ready = 1'b0;

    // presses while busy are ignored
    bits = 16'hFFFF;
    press_clean();
    press_clean();
    check_eq("t4_a_unchanged", op_if.a_coeffs, 32'h0101);
    check_eq("t4_b_unchanged", op_if.b_coeffs, 32'h4321);
    check_eq("t4_state_busy", load_state, 32'(S_BUSY));
    op_if.mult_done = 1'b1;
    tick(1);
    op_if.mult_done = 1'b0;
    check_eq("t4_state_load_a", load_state, 32'(S_LOAD_A));
    check_eq("t4_a_not_cleared", op_if.a_coeffs, 32'h0101);

    // bouncy press: 5-cycle toggles for 40 cycles, then stable high
    for (int i = 0; i < 8; i++) begin
      step_btn = ~step_btn;
      tick(5);
    end
    step_btn = 1'b1;
    tick(30);
    check_eq("t2_one_capture_state", load_state, 32'(S_LOAD_B));
    check_eq("t2_a_ffff", op_if.a_coeffs, 32'hFFFF);
    check_eq("t2_b_unchanged", op_if.b_coeffs, 32'h4321);
    step_btn = 1'b0;
    tick(30);

    // 10-cycle glitch is shorter than the debounce window
    bits = 16'h00AA;
    tick(2);
    step_btn = 1'b1;
    tick(10);
    step_btn = 1'b0;
    tick(30);
    check_eq("t2_glitch_state", load_state, 32'(S_LOAD_B));
    check_eq("t2_glitch_b", op_if.b_coeffs, 32'h4321);

    // reach S_ISSUE again, then reset with no clock edge
    bits = 16'h8765;
    tick(2);
    step_btn = 1'b1;
    wait_state("t5_issue_timeout", S_ISSUE, 40, lat);
    check_eq("t5_b", op_if.b_coeffs, 32'h8765);
    man_reset_n = 1'b0;
    #1;
    check_eq("t5_valid", op_if.op_valid, 32'h0);
    check_eq("t5_a", op_if.a_coeffs, 32'h0);
    check_eq("t5_b_cleared", op_if.b_coeffs, 32'h0);
    check_eq("t5_state", load_state, 32'(S_LOAD_A));
    exp_q.delete();
    step_btn       = 1'b0;
    op_if.op_ready = 1'b1;
    tick(3);
    man_reset_n = 1'b1;
    tick(2);

    // op_ready high from reset; stray mult_done in S_LOAD_A
    op_if.mult_done = 1'b1;
    tick(1);
    op_if.mult_done = 1'b0;
    tick(1);
    check_eq("t6_stray_done_state", load_state, 32'(S_LOAD_A));
    check_eq("t6_stray_done_a", op_if.a_coeffs, 32'h0);
    bits = 16'h0F0F;
    press_clean();
    check_eq("t6_state_load_b", load_state, 32'(S_LOAD_B));
    check_eq("t6_a", op_if.a_coeffs, 32'h0F0F);
    bits = 16'hF0F0;
    tick(2);
    exp_q.push_back({16'h0F0F, 16'hF0F0});
    step_btn = 1'b1;
    wait_state("t6_issue_timeout", S_ISSUE, 40, lat);
    check_eq("t6_valid", op_if.op_valid, 32'h1);
    check_eq("t6_b", op_if.b_coeffs, 32'hF0F0);
    tick(1);
    check_eq("t6_single_issue_cycle", load_state, 32'(S_BUSY));
    check_eq("t6_valid_dropped", op_if.op_valid, 32'h0);
    step_btn = 1'b0;
    tick(30);
    op_if.op_ready = 1'b0;

    // press pulse and mult_done together in S_BUSY: return without capture
    bits = 16'h5555;
    tick(2);
    step_btn = 1'b1;
    tick(SYNC + DEB);
    op_if.mult_done = 1'b1;
    tick(1);
    op_if.mult_done = 1'b0;
    check_eq("t7_state_load_a", load_state, 32'(S_LOAD_A));
    check_eq("t7_a_kept", op_if.a_coeffs, 32'h0F0F);
    step_btn = 1'b0;
    tick(30);
    check_eq("t7_state_still_load_a", load_state, 32'(S_LOAD_A));
    check_eq("t7_a_still_kept", op_if.a_coeffs, 32'h0F0F);

    // final report
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
